// File: rtl/spi_ss_sequencer.sv
// SPI mode-0 receive sequencer with N_SS active-low slave selects.
// A transaction is launched by an explicit start/sel request or automatically
// in round-robin scan mode. The request is accepted on one edge, and ss_n
// asserts on the following edge. The sequence then runs setup, DATA_W
// SCLK periods and hold. The received word is published together with a
// one-cycle done pulse when ss_n deasserts.
module spi_ss_sequencer #(
    parameter int N_SS     = 2,
    parameter int DATA_W   = 8,
    parameter int CLK_DIV  = 4,
    parameter int CS_SETUP = 2,
    parameter int CS_HOLD  = 2,
    localparam int SEL_W   = $clog2(N_SS)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [SEL_W-1:0]  sel,
    input  logic              scan_en,
    input  logic              miso,
    output logic              sclk,
    output logic [N_SS-1:0]   ss_n,
    output logic              busy,
    output logic [DATA_W-1:0] rx_data,
    output logic [SEL_W-1:0]  rx_ch,
    output logic              done,
    output logic              sel_err
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SETUP = 2'd1;
    localparam logic [1:0] ST_SHIFT = 2'd2;
    localparam logic [1:0] ST_HOLD  = 2'd3;

    // An 8-bit timer covers CLK_DIV up to 255 and the 4-bit setup/hold counts.
    // A 6-bit bit counter covers DATA_W up to 32.
    localparam logic [7:0] SETUP_LAST = 8'(CS_SETUP - 1);
    localparam logic [7:0] DIV_LAST   = 8'(CLK_DIV - 1);
    localparam logic [7:0] HOLD_LAST  = 8'(CS_HOLD - 1);
    localparam logic [5:0] BIT_LAST   = 6'(DATA_W - 1);
    localparam logic [SEL_W-1:0] PTR_LAST = SEL_W'(N_SS - 1);
    localparam logic [N_SS-1:0]  ONE_HOT0 = N_SS'(1);

    logic [1:0]        state;
    logic              launch;     // request accepted, ss_n asserts next edge
    logic [SEL_W-1:0]  chan;       // channel of the pending/active transaction
    logic              scan_txn;   // active transaction came from scan mode
    logic [SEL_W-1:0]  scan_ptr;
    logic [7:0]        tmr;
    logic [5:0]        bit_cnt;
    logic [DATA_W-1:0] shreg;

    logic sel_ok;
    logic tick_last;
    logic sample;
    logic fall;

    assign sel_ok = (32'(sel) < 32'(N_SS));
    assign sample = (state == ST_SHIFT) && tick_last && !sclk;
    assign fall   = (state == ST_SHIFT) && tick_last && sclk;

    // Flag the last cycle of the current setup, half-period or hold interval.
    always_comb begin
        tick_last = 1'b0;
        case (state)
            ST_SETUP: tick_last = (tmr == SETUP_LAST);
            ST_SHIFT: tick_last = (tmr == DIV_LAST);
            ST_HOLD:  tick_last = (tmr == HOLD_LAST);
            default:  tick_last = 1'b0;
        endcase
    end

    // Interval timer: restarts at every phase boundary and sits at zero in IDLE.
    // NOTE: registers use non-blocking assignments so every always_ff reads pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tmr <= '0;
        end else if (state == ST_IDLE || tick_last) begin
            tmr <= '0;
        end else begin
            tmr <= tmr + 8'd1;
        end
    end

    // Bit counter: cleared during setup and advanced on each falling SCLK edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bit_cnt <= '0;
        end else if (state == ST_SETUP) begin
            bit_cnt <= '0;
        end else if (fall) begin
            bit_cnt <= bit_cnt + 6'd1;
        end
    end

    // Shift miso in MSB first on the edge that raises sclk. This register stays internal.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            shreg <= '0;
        end else if (sample) begin
            shreg <= DATA_W'({shreg, miso});
        end
    end

    // Control FSM and all registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= ST_IDLE;
            launch   <= 1'b0;
            chan     <= '0;
            scan_txn <= 1'b0;
            scan_ptr <= '0;
            sclk     <= 1'b0;
            ss_n     <= '1;
            busy     <= 1'b0;
            done     <= 1'b0;
            sel_err  <= 1'b0;
            rx_data  <= '0;
            rx_ch    <= '0;
        end else begin
            done    <= 1'b0;
            sel_err <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (launch) begin
                        launch <= 1'b0;
                        state  <= ST_SETUP;
                        busy   <= 1'b1;
                        ss_n   <= ~(ONE_HOT0 << chan);
                    end else if (scan_en) begin
                        launch   <= 1'b1;
                        chan     <= scan_ptr;
                        scan_txn <= 1'b1;
                    end else if (start) begin
                        if (sel_ok) begin
                            launch   <= 1'b1;
                            chan     <= sel;
                            scan_txn <= 1'b0;
                        end else begin
                            sel_err <= 1'b1;
                        end
                    end
                end
                ST_SETUP: begin
                    if (tick_last) begin
                        state <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (sample) begin
                        sclk <= 1'b1;
                    end else if (fall) begin
                        sclk <= 1'b0;
                        if (bit_cnt == BIT_LAST) begin
                            state <= ST_HOLD;
                        end
                    end
                end
                ST_HOLD: begin
                    if (tick_last) begin
                        state   <= ST_IDLE;
                        busy    <= 1'b0;
                        ss_n    <= '1;
                        done    <= 1'b1;
                        rx_data <= shreg;
                        rx_ch   <= chan;
                        if (scan_txn) begin
                            scan_ptr <= (scan_ptr == PTR_LAST) ? '0 : scan_ptr + 1'b1;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: doc/spi_ss_sequencer.md
SPI_SS_SEQUENCER -- requirements
Module: spi_ss_sequencer

Interface
REQ-001 SHALL have parameter N_SS, default 2, meaning the number of slave-select channels (legal range 2..8).
REQ-002 SHALL have parameter DATA_W, default 8, meaning the number of bits received per transaction (legal range 1..32).
REQ-003 SHALL have parameter CLK_DIV, default 4, meaning the number of clk cycles per SCLK half-period (legal range 1..255).
REQ-004 SHALL have parameter CS_SETUP, default 2, meaning clk cycles from ss_n assertion to the first SCLK low phase (legal range 1..15).
REQ-005 SHALL have parameter CS_HOLD, default 2, meaning clk cycles from the last SCLK fall to ss_n deassertion (legal range 1..15).
REQ-006 SHALL have ports (name  direction  width  meaning): clk  in  1  single clock, all logic on rising edge.
REQ-007 reset_n  in  1  asynchronous, active-low reset.
REQ-008 start  in  1  one-cycle transaction request.
REQ-009 sel  in  clog2(N_SS)  channel index for start.
REQ-010 scan_en  in  1  auto round-robin mode enable.
REQ-011 miso  in  1  serial data from the selected slave.
REQ-012 sclk  out  1  SPI clock, mode 0, idle low.
REQ-013 ss_n  out  N_SS  active-low slave selects.
REQ-014 busy  out  1  high whenever state is not IDLE.
REQ-015 rx_data  out  DATA_W  last received word.
REQ-016 rx_ch  out  clog2(N_SS)  channel rx_data came from.
REQ-017 done  out  1  one-cycle pulse when rx_data/rx_ch update.
REQ-018 sel_err  out  1  one-cycle pulse for a rejected sel.

Function
REQ-019 SHALL implement states IDLE, SETUP, SHIFT, HOLD, with registered outputs only.
REQ-020 IDLE with scan_en=0, start=1, sel<N_SS: SHALL latch sel into the active channel and enter SETUP on the next edge.
REQ-021 IDLE with scan_en=0, start=1, sel>=N_SS: SHALL pulse sel_err the next cycle, stay IDLE, and leave ss_n unchanged.
REQ-022 IDLE with scan_en=1: SHALL ignore start and launch a transaction to the scan pointer, which resets to 0 and increments modulo N_SS after each completed scan transaction.
REQ-023 Exactly the active channel's ss_n bit SHALL be low for every cycle in SETUP, SHIFT and HOLD; all other bits SHALL be high.
REQ-024 SETUP SHALL last CS_SETUP cycles with sclk=0.
REQ-025 SHIFT SHALL run DATA_W bit periods, each CLK_DIV cycles of sclk=0 then CLK_DIV cycles of sclk=1.
REQ-026 miso SHALL be sampled on the clk edge where sclk transitions 0->1, with bits shifted in MSB first.
REQ-027 HOLD SHALL last CS_HOLD cycles with sclk=0.
REQ-028 On the HOLD->IDLE edge: all ss_n SHALL go high, rx_data/rx_ch SHALL update, and done SHALL be 1 for exactly one cycle.
REQ-029 Latency from the start-sampling edge to the done-high cycle SHALL be 1+CS_SETUP+2*CLK_DIV*DATA_W+CS_HOLD cycles.
REQ-030 In scan mode, back-to-back transactions SHALL have at least one IDLE cycle, with all ss_n high, between them.
REQ-031 start while busy SHALL be ignored, with no queuing.
REQ-032 sel and scan_en changes while busy SHALL NOT affect the active transaction; if scan_en falls mid-transaction, that transaction completes (done pulses, scan pointer increments) and the block then idles.
REQ-033 rx_data SHALL hold its value between done pulses; the shift register SHALL NOT be visible on rx_data mid-transaction.
REQ-034 Internal counters SHALL be sized for the maximum legal parameters without wrap-around.

Reset
REQ-035 reset_n=0 SHALL immediately (asynchronously) force: state IDLE, ss_n all 1, sclk 0, busy 0, done 0, sel_err 0, rx_data 0, rx_ch 0, scan pointer 0.
REQ-036 Reset asserted mid-transaction SHALL abort it with no done pulse and no rx_data update.
REQ-037 After reset_n deassertion, the first start SHALL be honoured no earlier than the first rising clk edge that follows.

Verification
REQ-038 Defaults; start, sel=1; miso drives 0xA5 MSB-first on the rising SCLK edges -> ss_n=2'b01 throughout, 8 SCLK pulses, done at cycle 1+2+64+2=69, rx_data=0xA5, rx_ch=1.
REQ-039 N_SS=3; start, sel=3 -> sel_err pulse, ss_n stays 3'b111, busy stays 0.
REQ-040 N_SS=4; scan_en=1 for 4 transactions with miso constant 1 -> ss_n low in order 0,1,2,3, rx_ch 0..3, rx_data=0xFF, at least 1 all-high idle cycle between transactions; pointer wraps back to 0.
REQ-041 start pulsed again in the SHIFT state -> ignored; exactly one done pulse.
REQ-042 reset_n low during SHIFT at bit 4 -> ss_n all high and sclk 0 in the same cycle, no done, rx_data keeps 0.
REQ-043 CLK_DIV=1, DATA_W=1, CS_SETUP=1, CS_HOLD=1; start with miso=1 -> done at cycle 5, rx_data=1.
